// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Storage array for level_fifo. DWIDTH x 2^LOG2_SZ entries,
//               synchronous write, asynchronous (combinational) read.
//               Contents are not reset.
// Ports       : clk     - clock, write occurs on posedge
//               wr_en   - write enable
//               wr_addr - write address
//               wr_data - write data
//               rd_addr - read address
//               rd_data - read data (combinational from rd_addr)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int DWIDTH  = 8,
    parameter int LOG2_SZ = 3
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [LOG2_SZ-1:0] wr_addr,
    input  logic [DWIDTH-1:0]  wr_data,
    input  logic [LOG2_SZ-1:0] rd_addr,
    output logic [DWIDTH-1:0]  rd_data
);

    localparam int c_DEPTH = 1 << LOG2_SZ;

    logic [DWIDTH-1:0] r_mem_q [c_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/level_fifo.sv
`default_nettype none
// ============================================================================
// Module      : level_fifo
// Description : Synchronous FIFO with level reporting, almost-full/empty
//               thresholds, sticky overflow/underflow flags and an optional
//               output register (OUT_REG=1 adds one entry of capacity).
// Ports       : clk                     - clock
//               reset                   - synchronous active-high reset
//               data_in / data_in_strobe - write data / write request
//               data_in_ready           - storage has space
//               data_out / data_out_valid - head entry / head valid
//               data_out_consume_strobe - pop head entry
//               flush                   - synchronous discard of contents
//               level                   - number of entries held
//               almost_full/almost_empty - threshold flags from level
//               overflow/underflow      - sticky illegal-access flags
// Revision    : 1.0 - initial release
// ============================================================================
module level_fifo #(
    parameter int DWIDTH   = 8,
    parameter int LOG2_SZ  = 3,
    parameter int OUT_REG  = 0,
    parameter int AF_LEVEL = (1 << LOG2_SZ) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DWIDTH-1:0]  data_in,
    input  logic               data_in_strobe,
    output logic               data_in_ready,
    output logic [DWIDTH-1:0]  data_out,
    output logic               data_out_valid,
    input  logic               data_out_consume_strobe,
    input  logic               flush,
    output logic [LOG2_SZ:0]   level,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);

    localparam int          c_PW = LOG2_SZ + 1;
    localparam logic [31:0] c_AF = AF_LEVEL;
    localparam logic [31:0] c_AE = AE_LEVEL;
    localparam logic [c_PW-1:0] c_PTR_ONE = {{LOG2_SZ{1'b0}}, 1'b1};

    logic [c_PW-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PW-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic              r_overflow_q, w_overflow_d;
    logic              r_underflow_q, w_underflow_d;

    logic              w_mem_empty;
    logic              w_mem_full;
    logic [c_PW-1:0]   w_mem_count;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_mem_push;
    logic              w_mem_pop;
    logic [DWIDTH-1:0] w_ram_rdata;
    logic              w_out_valid;
    logic [DWIDTH-1:0] w_out_data;
    logic [c_PW-1:0]   w_level;
    logic [31:0]       w_level32;

    // Wrap bit distinguishes full from empty when the low bits match.
    assign w_mem_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign w_mem_full  = (r_wr_ptr_q[LOG2_SZ-1:0] == r_rd_ptr_q[LOG2_SZ-1:0]) &&
                         (r_wr_ptr_q[LOG2_SZ] != r_rd_ptr_q[LOG2_SZ]);
    assign w_mem_count = r_wr_ptr_q - r_rd_ptr_q;

    // Acceptance uses pre-edge state only, so a consume never frees a slot
    // for a write on the same edge.
    assign data_in_ready = !w_mem_full;
    assign w_wr_acc      = data_in_strobe && !w_mem_full;
    assign w_rd_acc      = data_out_consume_strobe && w_out_valid;

    fifo_ram #(
        .DWIDTH  (DWIDTH),
        .LOG2_SZ (LOG2_SZ)
    ) u_fifo_ram (
        .clk     (clk),
        .wr_en   (w_mem_push && !flush),
        .wr_addr (r_wr_ptr_q[LOG2_SZ-1:0]),
        .wr_data (data_in),
        .rd_addr (r_rd_ptr_q[LOG2_SZ-1:0]),
        .rd_data (w_ram_rdata)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_ov_q, w_ov_d;
            logic [DWIDTH-1:0] r_od_q, w_od_d;
            logic              w_load;
            logic              w_bypass;

            // The register refills whenever it is empty or being consumed.
            // With storage empty, an accepted write that coincides with a
            // consume goes straight into the register so streaming at level
            // one has no bubble.
            always_comb begin
                w_load   = !r_ov_q || w_rd_acc;
                w_bypass = w_mem_empty && r_ov_q && w_rd_acc && w_wr_acc;
                w_ov_d   = r_ov_q;
                w_od_d   = r_od_q;
                if (flush) begin
                    w_ov_d = 1'b0;
                end else if (w_load) begin
                    if (!w_mem_empty) begin
                        w_ov_d = 1'b1;
                        w_od_d = w_ram_rdata;
                    end else if (w_bypass) begin
                        w_ov_d = 1'b1;
                        w_od_d = data_in;
                    end else begin
                        w_ov_d = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ov_q <= 1'b0;
                end else begin
                    r_ov_q <= w_ov_d;
                end
            end

            // Data register needs no reset; it is qualified by r_ov_q.
            always_ff @(posedge clk) begin
                r_od_q <= w_od_d;
            end

            assign w_mem_pop   = w_load && !w_mem_empty;
            assign w_mem_push  = w_wr_acc && !w_bypass;
            assign w_out_valid = r_ov_q;
            assign w_out_data  = r_od_q;
            assign w_level     = w_mem_count + {{LOG2_SZ{1'b0}}, r_ov_q};
        end else begin : g_no_out_reg
            assign w_mem_pop   = w_rd_acc;
            assign w_mem_push  = w_wr_acc;
            assign w_out_valid = !w_mem_empty;
            assign w_out_data  = w_ram_rdata;
            assign w_level     = w_mem_count;
        end
    endgenerate

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_overflow_d  = r_overflow_q;
        w_underflow_d = r_underflow_q;
        if (flush) begin
            // Flush drops concurrent accesses and leaves sticky flags alone.
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else begin
            if (w_mem_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            end
            if (w_mem_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            end
            if (data_in_strobe && !data_in_ready) begin
                w_overflow_d = 1'b1;
            end
            if (data_out_consume_strobe && !w_out_valid) begin
                w_underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    assign w_level32      = {{(32 - c_PW){1'b0}}, w_level};
    assign level          = w_level;
    assign almost_full    = (w_level32 >= c_AF);
    assign almost_empty   = (w_level32 <= c_AE);
    assign data_out       = w_out_data;
    assign data_out_valid = w_out_valid;
    assign overflow       = r_overflow_q;
    assign underflow      = r_underflow_q;

`ifdef SIM
    always_ff @(posedge clk) begin
        if (!reset && !flush && data_in_strobe && !data_in_ready) begin
            $fatal(1, "level_fifo: write while full");
        end
        if (!reset && !flush && data_out_consume_strobe && !w_out_valid) begin
            $fatal(1, "level_fifo: consume while empty");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_level_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_fifo
// Description : Scoreboard bench for level_fifo. Two instances (OUT_REG=0 and
//               OUT_REG=1) share one stimulus stream; each has its own queue
//               reference model. Directed scenarios first, then random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       win = 1'b0;
    logic       cin = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout [2];
    logic       dval [2];
    logic       rdy  [2];
    logic       af   [2];
    logic       ae   [2];
    logic       ovf  [2];
    logic       udf  [2];
    logic [3:0] lvl  [2];

    always #5 clk = ~clk;

    level_fifo #(.DWIDTH(8), .LOG2_SZ(3), .OUT_REG(0)) u_fifo0 (
        .clk(clk), .reset(reset), .data_in(din), .data_in_strobe(win),
        .data_in_ready(rdy[0]), .data_out(dout[0]), .data_out_valid(dval[0]),
        .data_out_consume_strobe(cin), .flush(flush), .level(lvl[0]),
        .almost_full(af[0]), .almost_empty(ae[0]),
        .overflow(ovf[0]), .underflow(udf[0])
    );

    level_fifo #(.DWIDTH(8), .LOG2_SZ(3), .OUT_REG(1)) u_fifo1 (
        .clk(clk), .reset(reset), .data_in(din), .data_in_strobe(win),
        .data_in_ready(rdy[1]), .data_out(dout[1]), .data_out_valid(dval[1]),
        .data_out_consume_strobe(cin), .flush(flush), .level(lvl[1]),
        .almost_full(af[1]), .almost_empty(ae[1]),
        .overflow(ovf[1]), .underflow(udf[1])
    );

    // Reference model: contents as a queue, visibility and sticky flags.
    logic [7:0] mq [2][$];
    logic [7:0] sb [2][$];
    bit         mvalid [2];
    bit         movf   [2];
    bit         mudf   [2];
    int         n_pass  = 0;
    int         n_total = 0;
    bit         started = 1'b0;

    function automatic int cap_of(input int k);
        return (k == 0) ? 8 : 9;
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[inst%0d]: got %0h expected %0h at %0t", name, k, act, exp, $time);
    endfunction

    task automatic model_step(input int k);
        int pre;
        bit wa;
        bit ra;
        if (reset) begin
            mq[k].delete();
            mvalid[k] = 1'b0;
            movf[k]   = 1'b0;
            mudf[k]   = 1'b0;
        end else if (flush) begin
            mq[k].delete();
            mvalid[k] = 1'b0;
        end else begin
            pre = mq[k].size();
            wa  = win && (pre < cap_of(k));
            ra  = cin && mvalid[k];
            if (win && !wa) movf[k] = 1'b1;
            if (cin && !ra) mudf[k] = 1'b1;
            if (ra) void'(mq[k].pop_front());
            if (wa) mq[k].push_back(din);
            // Combinational output: head visible as soon as it exists.
            // Registered output: head visible if it was already held before
            // this edge, or it replaced a consumed head (streaming).
            if (k == 0) mvalid[k] = (mq[k].size() > 0);
            else        mvalid[k] = (mq[k].size() > 0) && (ra || pre > 0);
        end
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit c,
                         input bit f = 1'b0, input bit r = 1'b0);
        win   = w;
        din   = d;
        cin   = c;
        flush = f;
        reset = r;
        for (int k = 0; k < 2; k++) begin
            if (c && mvalid[k]) sb[k].push_back(mq[k][0]);
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    // Monitor: status every cycle, data whenever the DUT presents a head
    // that is being consumed.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("level", k, 32'(lvl[k]), 32'(mq[k].size()));
                chk("valid", k, 32'(dval[k]), 32'(mvalid[k]));
                chk("ready", k, 32'(rdy[k]), 32'(mq[k].size() < cap_of(k)));
                chk("almost_full", k, 32'(af[k]), 32'(mq[k].size() >= 7));
                chk("almost_empty", k, 32'(ae[k]), 32'(mq[k].size() <= 1));
                chk("overflow", k, 32'(ovf[k]), 32'(movf[k]));
                chk("underflow", k, 32'(udf[k]), 32'(mudf[k]));
                if (dval[k] && cin) begin
                    if (sb[k].size() == 0) chk("sb_depth", k, 32'(sb[k].size()), 32'd1);
                    else                   chk("data", k, 32'(dout[k]), 32'(sb[k].pop_front()));
                end
            end
        end
    end

    initial begin
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 0, 0, 1);
        started = 1'b1;
        chk("rst_level", 0, 32'(lvl[0]), 32'd0);
        chk("rst_valid", 0, 32'(dval[0]), 32'd0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
        chk("rst_ae", 0, 32'(ae[0]), 32'd1);
        chk("rst_af", 0, 32'(af[0]), 32'd0);
        chk("rst_ovf", 1, 32'(ovf[1]), 32'd0);

        // Fill to capacity.
        for (int i = 0; i < 8; i++) drive(1, 8'(8'h10 + i), 0);
        chk("full_ready", 0, 32'(rdy[0]), 32'd0);
        chk("full_level", 0, 32'(lvl[0]), 32'd8);
        chk("full_af", 0, 32'(af[0]), 32'd1);
        chk("full_level", 1, 32'(lvl[1]), 32'd8);

        // Write+consume while full: write rejected on the 8-deep instance.
        drive(1, 8'h99, 1);
        chk("wc_full_ovf", 0, 32'(ovf[0]), 32'd1);
        chk("wc_full_level", 0, 32'(lvl[0]), 32'd7);
        chk("wc_full_head", 0, 32'(dout[0]), 32'h11);
        chk("wc_full_ovf", 1, 32'(ovf[1]), 32'd0);

        for (int i = 0; i < 7; i++) drive(0, 8'h00, 1);
        chk("drain_level", 0, 32'(lvl[0]), 32'd0);

        // Consume from empty.
        drive(0, 8'h00, 1);
        chk("empty_udf", 0, 32'(udf[0]), 32'd1);
        chk("empty_level", 0, 32'(lvl[0]), 32'd0);
        drive(0, 8'h00, 1);
        chk("empty_udf", 1, 32'(udf[1]), 32'd1);
        drive(0, 8'h00, 0, 0, 1);
        chk("rst_clears_udf", 0, 32'(udf[0]), 32'd0);
        chk("rst_clears_ovf", 0, 32'(ovf[0]), 32'd0);

        // Registered output latency and streaming.
        drive(1, 8'hA5, 0);
        chk("oreg_lat_valid", 1, 32'(dval[1]), 32'd0);
        chk("oreg_lat_level", 1, 32'(lvl[1]), 32'd1);
        drive(0, 8'h00, 0);
        chk("oreg_valid", 1, 32'(dval[1]), 32'd1);
        chk("oreg_data", 1, 32'(dout[1]), 32'hA5);
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(8'h30 + i), 1);
            chk("stream_valid", 1, 32'(dval[1]), 32'd1);
            chk("stream_level", 1, 32'(lvl[1]), 32'd1);
        end

        // Flush at level 5 with a concurrent write; sticky flags survive.
        drive(0, 8'h00, 0, 0, 1);
        drive(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h40 + i), 0);
        chk("pre_flush_level", 0, 32'(lvl[0]), 32'd5);
        drive(1, 8'hEE, 0, 1);
        chk("flush_level", 0, 32'(lvl[0]), 32'd0);
        chk("flush_valid", 0, 32'(dval[0]), 32'd0);
        chk("flush_udf", 0, 32'(udf[0]), 32'd1);
        chk("flush_valid", 1, 32'(dval[1]), 32'd0);

        // Random: write-heavy half, then consume-heavy half.
        drive(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 10000; i++) begin
            if (i < 5000)
                drive($urandom_range(0, 99) < 65, 8'($urandom), $urandom_range(0, 99) < 45,
                      $urandom_range(0, 199) == 0, $urandom_range(0, 999) < 3);
            else
                drive($urandom_range(0, 99) < 42, 8'($urandom), $urandom_range(0, 99) < 60,
                      $urandom_range(0, 199) == 0, $urandom_range(0, 999) < 3);
        end
        drive(0, 8'h00, 0);
        for (int k = 0; k < 2; k++) chk("sb_leftover", k, 32'(sb[k].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/level_fifo.md
LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 Parameter DWIDTH, default 8: data width in bits.
REQ-002 Parameter LOG2_SZ, default 3: storage array holds 2^LOG2_SZ entries, all usable (no reserved slot).
REQ-003 Parameter OUT_REG, default 0: 0 = data_out read combinationally from storage; 1 = data_out from an output register, capacity 2^LOG2_SZ+1.
REQ-004 Parameter AF_LEVEL, default 2^LOG2_SZ-1: almost_full threshold.
REQ-005 Parameter AE_LEVEL, default 1: almost_empty threshold.
REQ-006 clk  in  1  sole clock; all state changes on posedge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 data_in  in  DWIDTH  write data.
REQ-009 data_in_strobe  in  1  write request.
REQ-010 data_in_ready  out  1  space available.
REQ-011 data_out  out  DWIDTH  head-of-queue data.
REQ-012 data_out_valid  out  1  data_out is valid.
REQ-013 data_out_consume_strobe  in  1  consume head entry.
REQ-014 flush  in  1  synchronous discard of all contents.
REQ-015 level  out  LOG2_SZ+1  current entry count.
REQ-016 almost_full  out  1  level >= AF_LEVEL.
REQ-017 almost_empty  out  1  level <= AE_LEVEL.
REQ-018 overflow  out  1  sticky: write attempted while data_in_ready=0.
REQ-019 underflow  out  1  sticky: consume attempted while data_out_valid=0.

Function
REQ-020 Pointers SHALL be LOG2_SZ+1 bits (wrap bit); empty = pointers equal; full = low bits equal, wrap bits differ.
REQ-021 Write accepted at posedge iff data_in_strobe=1 and data_in_ready=1; otherwise write ignored, overflow set if strobe=1.
REQ-022 Consume accepted at posedge iff data_out_consume_strobe=1 and data_out_valid=1; otherwise ignored, underflow set if strobe=1.
REQ-023 Simultaneous accepted write and consume: level unchanged, both pointers advance.
REQ-024 When full, write with simultaneous consume is rejected (data_in_ready reflects pre-edge state); overflow set.
REQ-025 When empty, write with simultaneous consume: write accepted, consume rejected, underflow set.
REQ-026 OUT_REG=0: data written at edge N visible with data_out_valid=1 immediately after edge N.
REQ-027 OUT_REG=1: output register loads from storage (or directly from data_in when storage empty) when register empty or consumed; data written at edge N valid after edge N+1; no bubble under sustained write+consume.
REQ-028 data_out held stable while data_out_valid=1 and no consume accepted.
REQ-029 level = accepted writes minus accepted consumes, including output register when OUT_REG=1; never exceeds capacity.
REQ-030 almost_full, almost_empty combinational from level.
REQ-031 flush=1 at posedge: pointers, level, output-register valid cleared; concurrent write/consume discarded; sticky flags unaffected.
REQ-032 Sticky flags cleared only by reset.
REQ-033 Under `ifdef SIM, overflow/underflow events SHALL raise $fatal.

Reset
REQ-034 reset=1 at posedge overrides all other inputs, including flush and strobes.
REQ-035 After reset: level=0, data_out_valid=0, data_in_ready=1, almost_empty=1, almost_full=0 (unless AF_LEVEL=0), overflow=0, underflow=0.
REQ-036 Storage array not reset; data_out value undefined while data_out_valid=0.
REQ-037 Reset mid-operation discards all contents in one cycle.

Structure
REQ-038 No shared package; all constants are module parameters.
REQ-039 Storage SHALL be sub-module fifo_ram (async read, sync write, DWIDTH x 2^LOG2_SZ).

Verification
REQ-040 LOG2_SZ=3, OUT_REG=0: write 8 values 0x10..0x17 -> data_in_ready=0, level=8, almost_full=1; consume 8 -> same order, level=0.
REQ-041 Full FIFO, write+consume same edge -> write rejected, overflow=1, level=7, data_out next = second entry.
REQ-042 Empty FIFO, consume strobe -> underflow=1, level=0; reset clears flag.
REQ-043 OUT_REG=1: write 0xA5 at edge N -> data_out_valid=0 after N, =1 with 0xA5 after N+1; streaming 20 writes+consumes -> no bubble, level constant.
REQ-044 level=5, flush with concurrent write -> level=0, data_out_valid=0 next cycle; overflow/underflow unchanged.
REQ-045 Randomised 10k cycles vs queue model, both OUT_REG values -> data order and level match every cycle.
